// File: rtl/ring_link_buffer_pkg.sv
// Shared types and sizing constants for the inter-cluster ring link buffers.
package ring_link_buffer_pkg;

  localparam int ElenWidth = 64;

  typedef logic [ElenWidth-1:0] elen_t;
  typedef logic [$bits(elen_t)-1:0] ring_beat_t;

  // Two entries let the link stream one beat per cycle while still registering valid/ready.
  localparam int RingLinkDepth = 2;

endpackage

// File: rtl/ring_link_buffer.sv
// Elastic FIFO on one ring hop: registered valid/ready, flush on reconfiguration, saturating beat count.
// Define RING_LINK_PARITY_EN to store a per-entry even-parity bit and expose a sticky parity_err_o.
module ring_link_buffer
  import ring_link_buffer_pkg::*;
#(
  parameter int DataWidth = $bits(ring_beat_t),
  parameter int Depth     = RingLinkDepth,
  parameter int CntWidth  = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic [DataWidth-1:0]         data_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  output logic [DataWidth-1:0]         data_o,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic [$clog2(Depth+1)-1:0]   occupancy_o,
`ifdef RING_LINK_PARITY_EN
  output logic                         parity_err_o,
`endif
  output logic [CntWidth-1:0]          beats_o
);

  localparam int OccWidth = $clog2(Depth + 1);
  localparam int PtrWidth = $clog2(Depth);

  logic [DataWidth-1:0] mem_reg [Depth];
  logic [PtrWidth-1:0]  rd_ptr_reg, rd_ptr_next;
  logic [PtrWidth-1:0]  wr_ptr_reg, wr_ptr_next;
  logic [OccWidth-1:0]  count_reg, count_next;
  logic [CntWidth-1:0]  beats_reg, beats_next;
  logic                 do_push, do_pop;

  // Explicit wrap keeps non-power-of-two depths correct.
  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(Depth - 1)) ? '0 : p + PtrWidth'(1);
  endfunction

  assign ready_o     = (count_reg < OccWidth'(Depth));
  assign valid_o     = (count_reg != '0);
  assign data_o      = valid_o ? mem_reg[rd_ptr_reg] : '0;
  assign occupancy_o = count_reg;
  assign beats_o     = beats_reg;

  // Flush wins over any handshake in the same cycle.
  assign do_push = valid_i && ready_o && !flush_i;
  assign do_pop  = valid_o && ready_i && !flush_i;

  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    beats_next  = beats_reg;
    if (flush_i) begin
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      count_next  = '0;
      beats_next  = '0;
    end else begin
      if (do_push) wr_ptr_next = ptr_inc(wr_ptr_reg);
      if (do_pop)  rd_ptr_next = ptr_inc(rd_ptr_reg);
      case ({do_push, do_pop})
        2'b10:   count_next = count_reg + OccWidth'(1);
        2'b01:   count_next = count_reg - OccWidth'(1);
        default: count_next = count_reg;
      endcase
      if (do_pop && (beats_reg != '1)) beats_next = beats_reg + CntWidth'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      beats_reg  <= '0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
      beats_reg  <= beats_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_reg[wr_ptr_reg] <= data_i;
  end

`ifdef RING_LINK_PARITY_EN
  logic par_mem_reg [Depth];
  logic parity_err_reg;

  function automatic logic even_parity(input logic [DataWidth-1:0] d);
    return ^d;
  endfunction

  always_ff @(posedge clk_i) begin
    if (do_push) par_mem_reg[wr_ptr_reg] <= even_parity(data_i);
  end

  // Sticky until reset; flush deliberately leaves it alone so errors survive reconfiguration.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      parity_err_reg <= 1'b0;
    end else if (do_pop && (even_parity(data_o) != par_mem_reg[rd_ptr_reg])) begin
      parity_err_reg <= 1'b1;
    end
  end

  assign parity_err_o = parity_err_reg;
`endif

endmodule

// File: tb/tb_ring_link_buffer.sv
// Scoreboard bench: drivers queue expected beats, negedge monitors pop and compare on each DUT pop.
module tb_ring_link_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Instance A: default geometry (64-bit, Depth 2, 32-bit counter)
  logic        flush_a, valid_a, ready_in_a;
  logic [63:0] data_a;
  logic        ready_out_a, valid_out_a;
  logic [63:0] q_a;
  logic [1:0]  occ_a;
  logic [31:0] beats_a;

  // Instance B: Depth 3, 4-bit counter, exercises wrap and saturation
  logic        flush_b, valid_b, ready_in_b;
  logic [7:0]  data_b;
  logic        ready_out_b, valid_out_b;
  logic [7:0]  q_b;
  logic [1:0]  occ_b;
  logic [3:0]  beats_b;

`ifdef RING_LINK_PARITY_EN
  logic parity_err_a, parity_err_b;
`endif

  ring_link_buffer #(.DataWidth(64), .Depth(2), .CntWidth(32)) dut_a (
    .clk_i(clk), .rst_i(rst), .flush_i(flush_a),
    .data_i(data_a), .valid_i(valid_a), .ready_o(ready_out_a),
    .data_o(q_a), .valid_o(valid_out_a), .ready_i(ready_in_a),
    .occupancy_o(occ_a),
`ifdef RING_LINK_PARITY_EN
    .parity_err_o(parity_err_a),
`endif
    .beats_o(beats_a)
  );

  ring_link_buffer #(.DataWidth(8), .Depth(3), .CntWidth(4)) dut_b (
    .clk_i(clk), .rst_i(rst), .flush_i(flush_b),
    .data_i(data_b), .valid_i(valid_b), .ready_o(ready_out_b),
    .data_o(q_b), .valid_o(valid_out_b), .ready_i(ready_in_b),
    .occupancy_o(occ_b),
`ifdef RING_LINK_PARITY_EN
    .parity_err_o(parity_err_b),
`endif
    .beats_o(beats_b)
  );

  int tests = 0;
  int fails = 0;
  logic [63:0] exp_a[$];
  logic [7:0]  exp_b[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitors: a pop happens at the next rising edge when valid && ready && no flush/reset.
  always @(negedge clk) begin
    if (!rst && !flush_a && valid_out_a && ready_in_a) begin
      if (exp_a.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL a_unexpected: got %0h, expected no beat", q_a);
      end else begin
        $display("[TB] a out %0h", q_a);
        check("a_data", q_a, exp_a.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && !flush_b && valid_out_b && ready_in_b) begin
      if (exp_b.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL b_unexpected: got %0h, expected no beat", q_b);
      end else begin
        $display("[TB] b out %0h", q_b);
        check("b_data", {56'd0, q_b}, {56'd0, exp_b.pop_front()});
      end
    end
  end

  // Offer one beat to A; called at posedge+1, returns at posedge+1 after acceptance.
  task automatic send_a(input logic [63:0] d);
    int n = 0;
    valid_a = 1'b1;
    data_a  = d;
    @(negedge clk);
    while (!ready_out_a && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!ready_out_a) begin
      tests++;
      fails++;
      $display("FAIL a_send_timeout: got ready_o=0, expected 1 within 50 cycles");
    end else begin
      exp_a.push_back(d);
      $display("[TB] a in %0h", d);
    end
    step();
    valid_a = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int mcnt, acc, cyc;
    bit push, pop;

    rst = 1'b1;
    flush_a = 1'b0; valid_a = 1'b1; data_a = 64'hDEAD; ready_in_a = 1'b0;
    flush_b = 1'b0; valid_b = 1'b1; data_b = 8'hAD;    ready_in_b = 1'b0;
    step();
    step();
    rst = 1'b0; valid_a = 1'b0; valid_b = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_valid_a", valid_out_a, 0);
    check("rst_ready_a", ready_out_a, 1);
    check("rst_occ_a",   occ_a, 0);
    check("rst_beats_a", beats_a, 0);
    check("rst_data_a",  q_a, 0);
    check("rst_valid_b", valid_out_b, 0);
    check("rst_ready_b", ready_out_b, 1);
    check("rst_beats_b", beats_b, 0);
    step();

    // Streaming 0x1..0x10 at full rate
    ready_in_a = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      send_a(64'(i));
      check("a_stream_occ_le1", occ_a <= 2'd1, 1);
    end
    check("a_latency_valid", valid_out_a, 1);
    check("a_latency_data", q_a, 64'h10);
    step();
    step();
    check("a_stream_beats", beats_a, 16);
    check("a_stream_empty", valid_out_a, 0);

    // Backpressure: third beat is held upstream while full
    ready_in_a = 1'b0;
    send_a(64'hA);
    send_a(64'hB);
    valid_a = 1'b1;
    data_a  = 64'hC;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("a_full_ready", ready_out_a, 0);
      check("a_full_occ", occ_a, 2);
      check("a_stall_data", q_a, 64'hA);
    end
    step();
    ready_in_a = 1'b1;
    send_a(64'hC);
    repeat (3) step();
    check("a_bp_beats", beats_a, 19);
    check("a_bp_occ", occ_a, 0);

    // Flush with simultaneous push and pop offered
    ready_in_a = 1'b0;
    send_a(64'h5);
    send_a(64'h6);
    flush_a = 1'b1; valid_a = 1'b1; data_a = 64'h7; ready_in_a = 1'b1;
    step();
    flush_a = 1'b0; valid_a = 1'b0;
    exp_a.delete();
    check("a_flush_occ", occ_a, 0);
    check("a_flush_valid", valid_out_a, 0);
    check("a_flush_beats", beats_a, 0);
    repeat (4) step();
    check("a_flush_no7", valid_out_a, 0);

    // Flush with one entry: ready_o still reads 1 in the flush cycle
    ready_in_a = 1'b0;
    send_a(64'h8);
    flush_a = 1'b1; valid_a = 1'b1; data_a = 64'h9;
    @(negedge clk);
    check("a_flush_ready", ready_out_a, 1);
    step();
    flush_a = 1'b0; valid_a = 1'b0;
    exp_a.delete();
    check("a_flush2_occ", occ_a, 0);
    ready_in_a = 1'b1;
    send_a(64'h11);
    step();
    check("a_post_flush_beats", beats_a, 1);

    // B: 20 accepted beats with random downstream stalls, then drain
    mcnt = 0; acc = 0; cyc = 0;
    while (acc < 20 && cyc < 400) begin
      cyc++;
      valid_b    = 1'b1;
      data_b     = 8'(8'h30 + acc);
      ready_in_b = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("b_occ", occ_b, mcnt);
      check("b_ready", ready_out_b, mcnt < 3);
      push = (mcnt < 3);
      pop  = ready_in_b && (mcnt > 0);
      if (push) begin
        exp_b.push_back(data_b);
        $display("[TB] b in %0h", data_b);
        acc++;
      end
      mcnt = mcnt + int'(push) - int'(pop);
      step();
    end
    if (acc < 20) begin
      tests++;
      fails++;
      $display("FAIL b_fill_timeout: got %0d beats, expected 20", acc);
    end
    valid_b = 1'b0;
    ready_in_b = 1'b1;
    cyc = 0;
    while (mcnt > 0 && cyc < 10) begin
      cyc++;
      @(negedge clk);
      check("b_drain_occ", occ_b, mcnt);
      mcnt--;
      step();
    end
    check("b_drain_empty", occ_b, 0);
    check("b_beats_sat", beats_b, 4'hF);
    step();
    check("b_beats_hold", beats_b, 4'hF);

`ifdef RING_LINK_PARITY_EN
    // Corrupt a stored beat and check the sticky error
    ready_in_a = 1'b0;
    send_a(64'hFF);
    dut_a.mem_reg[dut_a.rd_ptr_reg] = 64'hFE;
    void'(exp_a.pop_back());
    exp_a.push_back(64'hFE);
    check("par_clean", parity_err_a, 0);
    ready_in_a = 1'b1;
    step();
    step();
    check("par_err_set", parity_err_a, 1);
    flush_a = 1'b1;
    step();
    flush_a = 1'b0;
    check("par_err_after_flush", parity_err_a, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("par_err_after_rst", parity_err_a, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
